hdlc_line_monitor: RTL and testbench

Synthesizable, multi-channel HDLC serial line monitor. It sits beside the Rx path on each HDLC line and produces several outputs per channel: flag, abort and idle detection, stuffed-zero removal strobes, and frame-boundary classification (good / frame error). It also keeps saturating error counters that software reads through a channel-select port. It succeeds the simulation-only Rx line checks by turning flag, abort, idle and zero-removal checking into parametrised hardware.

---
 rtl/hdlc_line_monitor.sv | 228 ++++++++++++++++++++++
 tb/tb_hdlc_line_monitor.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_line_monitor.sv
`default_nettype none
// ============================================================================
// Module      : hdlc_line_monitor
// Description : Multi-channel HDLC serial line monitor. For every channel it
//               detects flags, aborts, idle and stuffed zeros, classifies
//               each closed frame as good or bad by its de-stuffed payload
//               length, and keeps a saturating error counter per channel.
//               Counters are read through a channel-select mux.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous active-low reset
//   i_line_en[N]     per-channel bit valid; a bit is consumed only when high
//   i_line[N]        per-channel serial bit
//   i_clear_cnt      synchronous clear of all error counters (wins over +1)
//   i_cnt_sel        channel whose error counter drives o_err_count
//   o_flag_detect[N] pulse: flag 01111110 completed
//   o_abort_detect[N]pulse: 0 followed by seven ones completed
//   o_idle_detect[N] level: at least IDLE_LEN consecutive ones
//   o_zero_remove[N] pulse: stuffed zero dropped inside a frame
//   o_in_frame[N]    level: channel is ACTIVE
//   o_frame_ok[N]    pulse: closing flag ended a legal frame
//   o_frame_err[N]   pulse: closing flag ended an illegal frame
//   o_err_count      error counter of channel i_cnt_sel
// ============================================================================
module hdlc_line_monitor #(
    parameter  int NUM_CH   = 1,
    parameter  int IDLE_LEN = 8,
    parameter  int MIN_BITS = 32,
    parameter  int BCNT_W   = 12,
    parameter  int ERR_W    = 16,
    localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_line_en,
    input  logic [NUM_CH-1:0] i_line,
    input  logic              i_clear_cnt,
    input  logic [SEL_W-1:0]  i_cnt_sel,
    output logic [NUM_CH-1:0] o_flag_detect,
    output logic [NUM_CH-1:0] o_abort_detect,
    output logic [NUM_CH-1:0] o_idle_detect,
    output logic [NUM_CH-1:0] o_zero_remove,
    output logic [NUM_CH-1:0] o_in_frame,
    output logic [NUM_CH-1:0] o_frame_ok,
    output logic [NUM_CH-1:0] o_frame_err,
    output logic [ERR_W-1:0]  o_err_count
);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic [3:0]        c_idle_len  = 4'(IDLE_LEN);
    localparam logic [3:0]        c_run_five  = 4'd5;
    localparam logic [3:0]        c_run_six   = 4'd6;
    // The closing flag's leading 0 and six ones are counted as payload
    // before the flag can be recognised; they are subtracted back out.
    localparam logic [BCNT_W-1:0] c_flag_lead = BCNT_W'(7);
    localparam logic [BCNT_W-1:0] c_min_bits  = BCNT_W'(MIN_BITS);

    logic [NUM_CH-1:0][ERR_W-1:0] w_err_all;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch

        // Input stage
        logic              r_en;
        logic              r_bit;

        // Channel state
        logic [3:0]        r_run;
        state_t            r_state;
        state_t            w_state_next;
        logic [BCNT_W-1:0] r_bcnt;
        logic [BCNT_W-1:0] w_bcnt_next;
        logic [ERR_W-1:0]  r_err;

        // Registered outputs
        logic              r_flag;
        logic              r_abort;
        logic              r_idle;
        logic              r_zrem;
        logic              r_ok;
        logic              r_ferr;

        // Detection
        logic [3:0]        w_run_next;
        logic              w_flag;
        logic              w_abort;
        logic              w_stuff;
        logic              w_idle_evt;
        logic [BCNT_W-1:0] w_len;
        logic              w_len_good;
        logic              w_ok;
        logic              w_ferr;
        logic              w_err_inc;

        always_comb begin
            w_flag     = r_en && !r_bit && (r_run == c_run_six);
            w_abort    = r_en &&  r_bit && (r_run == c_run_six);
            w_stuff    = r_en && !r_bit && (r_run == c_run_five) &&
                         (r_state == ST_ACTIVE);

            if (!r_en) begin
                w_run_next = r_run;
            end else if (!r_bit) begin
                w_run_next = 4'd0;
            end else if (r_run >= c_idle_len) begin
                w_run_next = c_idle_len;
            end else begin
                w_run_next = r_run + 4'd1;
            end

            w_idle_evt = r_en && r_bit && (r_run != c_idle_len) &&
                         (w_run_next == c_idle_len);

            // Wraps on purpose when fewer than seven bits were counted; a
            // saturated counter can no longer give a trustworthy length.
            w_len      = r_bcnt - c_flag_lead;
            w_len_good = (w_len[2:0] == 3'd0) && (w_len >= c_min_bits) &&
                         !(&r_bcnt);
        end

        // Next-state and frame classification
        always_comb begin
            w_state_next = r_state;
            w_bcnt_next  = r_bcnt;
            w_ok         = 1'b0;
            w_ferr       = 1'b0;
            w_err_inc    = 1'b0;

            case (r_state)
                ST_HUNT: begin
                    if (w_flag) begin
                        w_state_next = ST_ACTIVE;
                        w_bcnt_next  = '0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_flag) begin
                        // Shared closing/opening flag: stay ACTIVE.
                        w_bcnt_next = '0;
                        if (w_len != '0) begin
                            if (w_len_good) begin
                                w_ok      = 1'b1;
                            end else begin
                                w_ferr    = 1'b1;
                                w_err_inc = 1'b1;
                            end
                        end
                    end else if (w_abort) begin
                        w_state_next = ST_HUNT;
                        w_err_inc    = 1'b1;
                    end else if (w_idle_evt) begin
                        w_state_next = ST_HUNT;
                    end else if (r_en && !w_stuff) begin
                        w_bcnt_next = (&r_bcnt) ? r_bcnt
                                                : r_bcnt + BCNT_W'(1);
                    end
                end
                default: begin
                    w_state_next = ST_HUNT;
                end
            endcase
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_en    <= 1'b0;
                r_bit   <= 1'b0;
                // Start saturated so a line idling high after reset is not
                // mistaken for an abort.
                r_run   <= c_idle_len;
                r_state <= ST_HUNT;
                r_bcnt  <= '0;
                r_err   <= '0;
                r_flag  <= 1'b0;
                r_abort <= 1'b0;
                r_idle  <= 1'b0;
                r_zrem  <= 1'b0;
                r_ok    <= 1'b0;
                r_ferr  <= 1'b0;
            end else begin
                r_en    <= i_line_en[g];
                r_bit   <= i_line[g];
                r_run   <= w_run_next;
                r_state <= w_state_next;
                r_bcnt  <= w_bcnt_next;
                r_flag  <= w_flag;
                r_abort <= w_abort;
                r_zrem  <= w_stuff;
                r_ok    <= w_ok;
                r_ferr  <= w_ferr;
                if (r_en) begin
                    r_idle <= (w_run_next == c_idle_len);
                end
                if (i_clear_cnt) begin
                    r_err <= '0;
                end else if (w_err_inc && !(&r_err)) begin
                    r_err <= r_err + ERR_W'(1);
                end
            end
        end

        assign o_flag_detect[g]  = r_flag;
        assign o_abort_detect[g] = r_abort;
        assign o_idle_detect[g]  = r_idle;
        assign o_zero_remove[g]  = r_zrem;
        assign o_in_frame[g]     = (r_state == ST_ACTIVE);
        assign o_frame_ok[g]     = r_ok;
        assign o_frame_err[g]    = r_ferr;
        assign w_err_all[g]      = r_err;
    end

    // Counter read-back; an out-of-range select reads zero.
    always_comb begin
        o_err_count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_cnt_sel == SEL_W'(i)) begin
                o_err_count = w_err_all[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hdlc_line_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdlc_line_monitor
// Description : Scoreboard bench for hdlc_line_monitor with four channels.
//               Stimulus queues expected pulse vectors (cycle-stamped) and
//               level snapshots; a negedge monitor compares the DUT against
//               them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdlc_line_monitor;

    localparam int K_NONE = 0;
    localparam int K_OK   = 1;
    localparam int K_ERR  = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  en    = 4'hF;
    logic [3:0]  line  = 4'hF;
    logic        clr   = 1'b0;
    logic [1:0]  sel   = 2'd0;
    logic        done  = 1'b0;

    logic [3:0]  o_flag, o_abort, o_idle, o_zrem, o_inf, o_ok, o_ferr;
    logic [15:0] o_err;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        int         cyc;
        logic [3:0] flag;
        logic [3:0] abrt;
        logic [3:0] zrem;
        logic [3:0] ok;
        logic [3:0] ferr;
    } ev_t;

    typedef struct packed {
        int          cyc;
        logic [3:0]  inf;
        logic [3:0]  idl;
        logic [15:0] err;
    } lv_t;

    ev_t sb[$];
    lv_t lq[$];
    ev_t nxt = '0;

    hdlc_line_monitor #(.NUM_CH(4)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_line_en      (en),
        .i_line         (line),
        .i_clear_cnt    (clr),
        .i_cnt_sel      (sel),
        .o_flag_detect  (o_flag),
        .o_abort_detect (o_abort),
        .o_idle_detect  (o_idle),
        .o_zero_remove  (o_zrem),
        .o_in_frame     (o_inf),
        .o_frame_ok     (o_ok),
        .o_frame_err    (o_ferr),
        .o_err_count    (o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [19:0] p;
        logic [19:0] pe;
        ev_t e;
        lv_t l;
        p = {o_flag, o_abort, o_zrem, o_ok, o_ferr};
        if (p != 20'd0) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL pulse_unexpected cyc=%0d got %05h (flag,abort,zrem,ok,ferr) required none", cyc, p);
            end else begin
                e  = sb.pop_front();
                pe = {e.flag, e.abrt, e.zrem, e.ok, e.ferr};
                if (e.cyc != cyc || pe !== p) begin
                    n_errors++;
                    $display("FAIL pulse cyc=%0d got %05h required %05h at cyc %0d", cyc, p, pe, e.cyc);
                end
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e  = sb.pop_front();
            pe = {e.flag, e.abrt, e.zrem, e.ok, e.ferr};
            n_checks++;
            n_errors++;
            $display("FAIL pulse_missing cyc=%0d got 00000 required %05h at cyc %0d", cyc, pe, e.cyc);
        end

        while (lq.size() != 0 && lq[0].cyc <= cyc) begin
            l = lq.pop_front();
            n_checks++;
            if (o_inf !== l.inf) begin
                n_errors++;
                $display("FAIL in_frame cyc=%0d got %b required %b", cyc, o_inf, l.inf);
            end
            n_checks++;
            if (o_idle !== l.idl) begin
                n_errors++;
                $display("FAIL idle cyc=%0d got %b required %b", cyc, o_idle, l.idl);
            end
            n_checks++;
            if (o_err !== l.err) begin
                n_errors++;
                $display("FAIL err_count sel=%0d cyc=%0d got %0d required %0d", sel, cyc, o_err, l.err);
            end
            n_checks++;
            if (p !== 20'd0) begin
                n_errors++;
                $display("FAIL quiet_pulses cyc=%0d got %05h required 00000", cyc, p);
            end
        end

        if (done) begin
            n_checks++;
            if (sb.size() != 0 || lq.size() != 0) begin
                n_errors++;
                $display("FAIL leftover got %0d pulse and %0d level entries required 0", sb.size(), lq.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $finish;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got no end of test required end", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        if ((nxt.flag | nxt.abrt | nxt.zrem | nxt.ok | nxt.ferr) != 4'd0) begin
            nxt.cyc = cyc + 2;
            sb.push_back(nxt);
        end
        nxt = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        en = 4'h0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic look(input logic [1:0] s, input logic [3:0] inf,
                        input logic [3:0] idl, input logic [15:0] err);
        lv_t l;
        sel   = s;
        l.cyc = cyc;
        l.inf = inf;
        l.idl = idl;
        l.err = err;
        lq.push_back(l);
        tick();
    endtask

    task automatic send_bit(input int ch, input logic b, input bit gap);
        line[ch] = b;
        en       = 4'h0;
        en[ch]   = 1'b1;
        tick();
        if (gap) begin
            en = 4'h0;
            tick();
        end
    endtask

    task automatic send_bits(input int ch, input logic [63:0] v, input int n,
                             input int zidx, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (i == zidx) nxt.zrem[ch] = 1'b1;
            send_bit(ch, v[i], gap);
        end
    endtask

    task automatic send_flag(input int ch, input int kind, input bit gap);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                nxt.flag[ch] = 1'b1;
                if (kind == K_OK)  nxt.ok[ch]   = 1'b1;
                if (kind == K_ERR) nxt.ferr[ch] = 1'b1;
            end
            send_bit(ch, (i != 0 && i != 7), gap);
        end
    endtask

    task automatic send_abort(input int ch);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) nxt.abrt[ch] = 1'b1;
            send_bit(ch, (i != 0), 1'b0);
        end
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        logic [39:0] v0;
        logic [39:0] v2;

        // Reset state, then idle ones on all channels.
        @(posedge clk); #1;
        tick();
        look(2'd0, 4'h0, 4'h0, 16'd0);
        rst_n = 1'b1;
        look(2'd0, 4'h0, 4'h0, 16'd0);
        look(2'd0, 4'h0, 4'h0, 16'd0);
        look(2'd0, 4'h0, 4'hF, 16'd0);
        for (int i = 0; i < 17; i++) tick();

        // Opening flag on ch0 after idle.
        send_flag(0, K_NONE, 1'b0);
        idle(2);
        look(2'd0, 4'b0001, 4'b1110, 16'd0);

        // 32-bit good frame, then a back-to-back flag (no frame pulse).
        send_bits(0, 64'hA5A5_A5A5, 32, -1, 1'b0);
        send_flag(0, K_OK, 1'b0);
        send_flag(0, K_NONE, 1'b0);
        idle(2);
        look(2'd0, 4'b0001, 4'b1110, 16'd0);

        // Five ones then a stuffed zero; 32 payload bits after removal.
        send_bits(0, 64'h1F, 33, 5, 1'b0);
        send_flag(0, K_OK, 1'b0);
        idle(2);
        look(2'd0, 4'b0001, 4'b1110, 16'd0);

        // 33-bit and 24-bit frames are illegal.
        send_bits(0, 64'h1_A5A5_A5A5, 33, -1, 1'b0);
        send_flag(0, K_ERR, 1'b0);
        send_bits(0, 64'hA5A5A5, 24, -1, 1'b0);
        send_flag(0, K_ERR, 1'b0);
        idle(2);
        look(2'd0, 4'b0001, 4'b1110, 16'd2);

        // ch2 opens a frame, then aborts while ch0 closes a good frame.
        send_flag(2, K_NONE, 1'b0);
        idle(2);
        look(2'd0, 4'b0101, 4'b1010, 16'd2);
        v0 = 40'h7E_A5A5_A5A5;
        v2 = 40'hFF_FFFE_A5A5;
        for (int i = 0; i < 40; i++) begin
            line[0] = v0[i];
            line[2] = v2[i];
            en      = 4'b0101;
            if (i == 39) begin
                nxt.flag[0] = 1'b1;
                nxt.ok[0]   = 1'b1;
            end
            if (i == 23) nxt.abrt[2] = 1'b1;
            tick();
        end
        idle(2);
        look(2'd2, 4'b0001, 4'b1110, 16'd1);
        look(2'd0, 4'b0001, 4'b1110, 16'd2);

        // Clear coinciding with a frame error increment on ch0.
        send_bits(0, 64'hA5, 8, -1, 1'b0);
        send_flag(0, K_ERR, 1'b0);
        clr = 1'b1;
        en  = 4'h0;
        tick();
        clr = 1'b0;
        idle(2);
        look(2'd0, 4'b0001, 4'b1110, 16'd0);
        look(2'd2, 4'b0001, 4'b1110, 16'd0);

        // Good frame with LineEn toggling every other cycle.
        send_bits(0, 64'hA5A5_A5A5, 32, -1, 1'b1);
        send_flag(0, K_OK, 1'b1);
        idle(2);
        look(2'd0, 4'b0001, 4'b1110, 16'd0);

        // Saturated bit counter on ch3 must give a frame error.
        send_flag(3, K_NONE, 1'b0);
        idle(2);
        look(2'd3, 4'b1001, 4'b0110, 16'd0);
        for (int i = 0; i < 4200; i++) send_bit(3, 1'b0, 1'b0);
        send_flag(3, K_ERR, 1'b0);
        idle(2);
        look(2'd3, 4'b1001, 4'b0110, 16'd1);

        // Abort while hunting: pulse only, no error.
        send_abort(1);
        idle(2);
        look(2'd1, 4'b1001, 4'b0100, 16'd0);

        // Reset in the middle of a ch0 frame.
        send_bits(0, 64'hA5A5, 16, -1, 1'b0);
        rst_n = 1'b0;
        en    = 4'hF;
        line  = 4'hF;
        look(2'd3, 4'h0, 4'h0, 16'd0);
        look(2'd0, 4'h0, 4'h0, 16'd0);
        rst_n = 1'b1;
        look(2'd0, 4'h0, 4'h0, 16'd0);
        look(2'd0, 4'h0, 4'h0, 16'd0);
        look(2'd0, 4'h0, 4'hF, 16'd0);
        idle(3);
        done = 1'b1;
    end

endmodule
`default_nettype wire
